// File: rtl/vdp_port_ctrl_if.sv
// Host-side I/O port bundle of the VDP port controller: port select, write
// data with its strobe, the end-of-read strobe and the read-back byte.
interface vdp_port_ctrl_if;
  logic       io_portsel;  // 0 = data port, 1 = control port
  logic [7:0] io_wrdata;
  logic       io_wren;     // one-cycle write strobe
  logic       io_rddone;   // one-cycle end-of-read strobe
  logic [7:0] io_rddata;

  modport master (
    output io_portsel,
    output io_wrdata,
    output io_wren,
    output io_rddone,
    input  io_rddata
  );

  modport slave (
    input  io_portsel,
    input  io_wrdata,
    input  io_wren,
    input  io_rddone,
    output io_rddata
  );
endinterface

// File: rtl/vdp_port_ctrl.sv
// VDP host port controller: decodes the two-byte control-port protocol into
// an address/code pair, register writes and interrupt enables, performs VRAM
// and palette writes through the data port, and keeps a one-byte read-ahead
// buffer filled by a two-cycle VRAM prefetch.
module vdp_port_ctrl (
  input  logic         clk,
  input  logic         reset_n,
  vdp_port_ctrl_if.slave io,
  output logic [13:0]  vram_addr,
  output logic [7:0]   vram_wrdata,
  output logic         vram_wren,
  output logic         vram_rden,
  input  logic [7:0]   vram_rddata,
  output logic [4:0]   pal_addr,
  output logic [7:0]   pal_wrdata,
  output logic         pal_wren,
  output logic [3:0]   reg_idx,
  output logic [7:0]   reg_data,
  output logic         reg_wr,
  input  logic         vsync_pend,
  input  logic         line_pend,
  input  logic         spr_ovf,
  input  logic         spr_coll,
  output logic         irq
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PF_REQ  = 2'd1,
    PF_WAIT = 2'd2
  } state_t;

  state_t      state_r, state_s;
  logic [1:0]  code_r, code_s;
  logic [13:0] addr_r, addr_s;
  logic        toggle_r, toggle_s;
  logic [7:0]  rdbuf_r, rdbuf_s;
  logic        vsync_r, vsync_s;
  logic        line_r, line_s;
  logic        ovf_r, ovf_s;
  logic        coll_r, coll_s;
  logic        ie_frame_r, ie_frame_s;
  logic        ie_line_r, ie_line_s;
  logic        reg_wr_r, reg_wr_s;
  logic [3:0]  reg_idx_r, reg_idx_s;
  logic [7:0]  reg_data_r, reg_data_s;
  logic        irq_r, irq_s;

  // A write always beats a coincident read strobe.
  logic wr_data_s, wr_ctrl_s, rd_data_s, rd_ctrl_s;
  assign wr_data_s = io.io_wren & ~io.io_portsel;
  assign wr_ctrl_s = io.io_wren &  io.io_portsel;
  assign rd_data_s = io.io_rddone & ~io.io_wren & ~io.io_portsel;
  assign rd_ctrl_s = io.io_rddone & ~io.io_wren &  io.io_portsel;

  // Next-state for the prefetch FSM, address/code/toggle, read buffer and register port.
  always_comb begin
    state_s    = state_r;
    code_s     = code_r;
    addr_s     = addr_r;
    toggle_s   = toggle_r;
    rdbuf_s    = rdbuf_r;
    ie_frame_s = ie_frame_r;
    ie_line_s  = ie_line_r;
    reg_wr_s   = 1'b0;
    reg_idx_s  = reg_idx_r;
    reg_data_s = reg_data_r;

    if (wr_data_s) begin
      // Data write cancels any prefetch; its own increment is the only one.
      rdbuf_s  = io.io_wrdata;
      addr_s   = addr_r + 14'd1;
      toggle_s = 1'b0;
      state_s  = IDLE;
    end else if (wr_ctrl_s) begin
      state_s = IDLE;
      if (toggle_r) begin
        code_s   = io.io_wrdata[7:6];
        addr_s   = {io.io_wrdata[5:0], addr_r[7:0]};
        toggle_s = 1'b0;
        case (io.io_wrdata[7:6])
          2'd0: state_s = PF_REQ;
          2'd2: begin
            reg_wr_s   = 1'b1;
            reg_idx_s  = io.io_wrdata[3:0];
            reg_data_s = addr_r[7:0];
            if (io.io_wrdata[3:0] == 4'd0) begin
              ie_line_s = addr_r[4];
            end else if (io.io_wrdata[3:0] == 4'd1) begin
              ie_frame_s = addr_r[5];
            end else begin
              ie_frame_s = ie_frame_r;
            end
          end
          default: state_s = IDLE;
        endcase
      end else begin
        addr_s   = {addr_r[13:8], io.io_wrdata};
        toggle_s = 1'b1;
      end
    end else if (rd_data_s) begin
      toggle_s = 1'b0;
      state_s  = PF_REQ;
    end else begin
      if (rd_ctrl_s) begin
        toggle_s = 1'b0;
      end else begin
        toggle_s = toggle_r;
      end
      case (state_r)
        PF_REQ:  state_s = PF_WAIT;
        PF_WAIT: begin
          rdbuf_s = vram_rddata;
          addr_s  = addr_r + 14'd1;
          state_s = IDLE;
        end
        default: state_s = IDLE;
      endcase
    end
  end

  // Status flags: a set pulse wins over a coincident status-read clear; irq follows the flags.
  always_comb begin
    vsync_s = (vsync_r & ~rd_ctrl_s) | vsync_pend;
    line_s  = (line_r  & ~rd_ctrl_s) | line_pend;
    ovf_s   = (ovf_r   & ~rd_ctrl_s) | spr_ovf;
    coll_s  = (coll_r  & ~rd_ctrl_s) | spr_coll;
    irq_s   = (vsync_r & ie_frame_r) | (line_r & ie_line_r);
  end

  // State register for every flop of the controller.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= IDLE;
      code_r     <= 2'd0;
      addr_r     <= 14'd0;
      toggle_r   <= 1'b0;
      rdbuf_r    <= 8'd0;
      vsync_r    <= 1'b0;
      line_r     <= 1'b0;
      ovf_r      <= 1'b0;
      coll_r     <= 1'b0;
      ie_frame_r <= 1'b0;
      ie_line_r  <= 1'b0;
      reg_wr_r   <= 1'b0;
      reg_idx_r  <= 4'd0;
      reg_data_r <= 8'd0;
      irq_r      <= 1'b0;
    end else begin
      state_r    <= state_s;
      code_r     <= code_s;
      addr_r     <= addr_s;
      toggle_r   <= toggle_s;
      rdbuf_r    <= rdbuf_s;
      vsync_r    <= vsync_s;
      line_r     <= line_s;
      ovf_r      <= ovf_s;
      coll_r     <= coll_s;
      ie_frame_r <= ie_frame_s;
      ie_line_r  <= ie_line_s;
      reg_wr_r   <= reg_wr_s;
      reg_idx_r  <= reg_idx_s;
      reg_data_r <= reg_data_s;
      irq_r      <= irq_s;
    end
  end

  // Write strobes must act in the same cycle, so these are decoded directly.
  assign vram_addr   = addr_r;
  assign vram_wrdata = io.io_wrdata;
  assign vram_wren   = wr_data_s & (code_r != 2'd3);
  assign vram_rden   = (state_r == PF_REQ) & ~io.io_wren;
  assign pal_addr    = addr_r[4:0];
  assign pal_wrdata  = io.io_wrdata;
  assign pal_wren    = wr_data_s & (code_r == 2'd3);
  assign reg_idx     = reg_idx_r;
  assign reg_data    = reg_data_r;
  assign reg_wr      = reg_wr_r;
  assign irq         = irq_r;
  assign io.io_rddata = io.io_portsel ? {vsync_r, ovf_r, coll_r, 5'd0} : rdbuf_r;

endmodule

// File: tb/tb_vdp_port_ctrl.sv
// Scoreboard bench for vdp_port_ctrl: stimulus tasks update a transaction-level
// model and queue the expected VRAM/palette/register events; a monitor pops and
// compares whenever the DUT raises a strobe.
module tb_vdp_port_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [13:0] vram_addr;
  logic [7:0]  vram_wrdata;
  logic        vram_wren;
  logic        vram_rden;
  logic [7:0]  vram_rddata;
  logic [4:0]  pal_addr;
  logic [7:0]  pal_wrdata;
  logic        pal_wren;
  logic [3:0]  reg_idx;
  logic [7:0]  reg_data;
  logic        reg_wr;
  logic        vsync_pend, line_pend, spr_ovf, spr_coll;
  logic        irq;

  vdp_port_ctrl_if io ();

  always #5 clk = ~clk;

  vdp_port_ctrl dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .io          (io),
    .vram_addr   (vram_addr),
    .vram_wrdata (vram_wrdata),
    .vram_wren   (vram_wren),
    .vram_rden   (vram_rden),
    .vram_rddata (vram_rddata),
    .pal_addr    (pal_addr),
    .pal_wrdata  (pal_wrdata),
    .pal_wren    (pal_wren),
    .reg_idx     (reg_idx),
    .reg_data    (reg_data),
    .reg_wr      (reg_wr),
    .vsync_pend  (vsync_pend),
    .line_pend   (line_pend),
    .spr_ovf     (spr_ovf),
    .spr_coll    (spr_coll),
    .irq         (irq)
  );

  // VRAM behind the DUT, and the model's own view of what VRAM should hold.
  logic [7:0] vram    [0:16383];
  logic [7:0] ref_mem [0:16383];

  // VRAM responder: read data appears the cycle after rden.
  always @(posedge clk) begin
    if (vram_rden) vram_rddata <= vram[vram_addr];
    if (vram_wren) vram[vram_addr] <= vram_wrdata;
  end

  localparam int EV_RD = 0, EV_VWR = 1, EV_PAL = 2, EV_REG = 3;
  typedef struct {
    int         kind;
    logic [13:0] addr;
    logic [7:0]  data;
  } ev_t;
  ev_t evq[$];

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state (behavioural: the port's architectural registers).
  logic [1:0]  m_code;
  logic [13:0] m_addr;
  logic        m_toggle;
  logic [7:0]  m_rdbuf;
  logic [3:0]  m_flags;  // [3] vsync, [2] line, [1] ovf, [0] coll
  logic        m_ie_frame, m_ie_line;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_ev(input int kind, input logic [13:0] a, input logic [7:0] d);
    ev_t e;
    e.kind = kind;
    e.addr = a;
    e.data = d;
    evq.push_back(e);
  endtask

  task automatic expect_ev(input int kind, input logic [13:0] a, input logic [7:0] d, input string name);
    ev_t e;
    if (evq.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: unexpected strobe at addr 0x%0h data 0x%0h, expected none", name, a, d);
    end else begin
      e = evq.pop_front();
      chk({name, " kind"}, kind, e.kind);
      chk({name, " addr"}, a, e.addr);
      if (kind != EV_RD) chk({name, " data"}, d, e.data);
    end
  endtask

  // Monitor: every strobe the DUT raises must match the next queued expectation.
  always @(negedge clk) begin
    if (reset_n) begin
      if (reg_wr)    expect_ev(EV_REG, {10'd0, reg_idx}, reg_data, "reg_wr");
      if (vram_rden) expect_ev(EV_RD, vram_addr, 8'd0, "vram_rden");
      if (vram_wren) expect_ev(EV_VWR, vram_addr, vram_wrdata, "vram_wren");
      if (pal_wren)  expect_ev(EV_PAL, {9'd0, pal_addr}, pal_wrdata, "pal_wren");
    end
  end

  task automatic m_reset();
    m_code = 2'd0; m_addr = 14'd0; m_toggle = 1'b0; m_rdbuf = 8'd0;
    m_flags = 4'd0; m_ie_frame = 1'b0; m_ie_line = 1'b0;
    evq.delete();
  endtask

  function automatic logic m_irq();
    return (m_flags[3] & m_ie_frame) | (m_flags[2] & m_ie_line);
  endfunction

  task automatic drive_clear();
    io.io_portsel = 1'b0; io.io_wrdata = 8'd0; io.io_wren = 1'b0; io.io_rddone = 1'b0;
    vsync_pend = 1'b0; line_pend = 1'b0; spr_ovf = 1'b0; spr_coll = 1'b0;
  endtask

  task automatic finish_cycle();
    @(posedge clk); #1;
    drive_clear();
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Called in the first prefetch cycle: expect rden there, a quiet wait cycle, then the load.
  task automatic settle_pf();
    logic [13:0] a;
    a = m_addr;
    push_ev(EV_RD, a, 8'd0);
    @(negedge clk);
    chk("prefetch rden", vram_rden, 1'b1);
    chk("prefetch addr", vram_addr, a);
    @(posedge clk); #1;
    @(negedge clk);
    chk("prefetch wait rden", vram_rden, 1'b0);
    @(posedge clk); #1;
    m_rdbuf = ref_mem[a];
    m_addr  = a + 14'd1;
  endtask

  // mode 0: no prefetch expected (reset follows); 1: full prefetch; 2: request only, caller aborts
  task automatic ctrl_wr(input logic [7:0] b, input int mode);
    logic pf;
    pf = 1'b0;
    io.io_portsel = 1'b1; io.io_wrdata = b; io.io_wren = 1'b1;
    if (!m_toggle) begin
      m_addr[7:0] = b;
      m_toggle = 1'b1;
    end else begin
      m_toggle = 1'b0;
      m_code = b[7:6];
      if (b[7:6] == 2'd2) begin
        push_ev(EV_REG, {10'd0, b[3:0]}, m_addr[7:0]);
        if (b[3:0] == 4'd0) m_ie_line = m_addr[4];
        if (b[3:0] == 4'd1) m_ie_frame = m_addr[5];
      end
      m_addr[13:8] = b[5:0];
      pf = (b[7:6] == 2'd0);
    end
    finish_cycle();
    if (pf && mode == 1) settle_pf();
    if (pf && mode == 2) push_ev(EV_RD, m_addr, 8'd0);
  endtask

  task automatic data_wr(input logic [7:0] b);
    io.io_portsel = 1'b0; io.io_wrdata = b; io.io_wren = 1'b1;
    if (m_code == 2'd3) begin
      push_ev(EV_PAL, {9'd0, m_addr[4:0]}, b);
    end else begin
      push_ev(EV_VWR, m_addr, b);
      ref_mem[m_addr] = b;
    end
    m_rdbuf  = b;
    m_addr   = m_addr + 14'd1;
    m_toggle = 1'b0;
    finish_cycle();
  endtask

  task automatic data_rd();
    io.io_portsel = 1'b0; io.io_rddone = 1'b1;
    @(negedge clk);
    chk("data read", io.io_rddata, m_rdbuf);
    m_toggle = 1'b0;
    finish_cycle();
    settle_pf();
  endtask

  task automatic ctrl_rd(input logic [3:0] set_mask);
    io.io_portsel = 1'b1; io.io_rddone = 1'b1;
    {vsync_pend, line_pend, spr_ovf, spr_coll} = set_mask;
    @(negedge clk);
    chk("status read", io.io_rddata, {m_flags[3], m_flags[1], m_flags[0], 5'd0});
    m_flags  = set_mask;
    m_toggle = 1'b0;
    finish_cycle();
  endtask

  task automatic pulse(input logic [3:0] mask);
    {vsync_pend, line_pend, spr_ovf, spr_coll} = mask;
    m_flags = m_flags | mask;
    finish_cycle();
  endtask

  task automatic check_irq(input string name);
    idle(2);
    @(negedge clk);
    chk(name, irq, m_irq());
    @(posedge clk); #1;
  endtask

  // Hard stop if the run ever stalls.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    logic [7:0] v;
    reset_n = 1'b0;
    drive_clear();
    m_reset();
    for (int i = 0; i < 16384; i++) begin
      v = 8'($urandom);
      vram[i] = v;
      ref_mem[i] = v;
    end
    vram[14'h1234] = 8'hAB;
    ref_mem[14'h1234] = 8'hAB;

    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("reset irq", irq, 1'b0);
    chk("reset vram_wren", vram_wren, 1'b0);
    chk("reset vram_rden", vram_rden, 1'b0);
    chk("reset pal_wren", pal_wren, 1'b0);
    chk("reset reg_wr", reg_wr, 1'b0);
    chk("reset vram_addr", vram_addr, 14'd0);
    chk("reset reg_idx", reg_idx, 4'd0);
    chk("reset reg_data", reg_data, 8'd0);
    chk("reset rddata", io.io_rddata, 8'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    idle(1);

    // Read prefetch from 0x1234, then a data read refetches from 0x1235.
    ctrl_wr(8'h34, 1);
    ctrl_wr(8'h12, 1);
    data_rd();

    // Two VRAM writes at 0x3F00/0x3F01; read buffer follows the last write.
    ctrl_wr(8'h00, 1);
    ctrl_wr(8'h7F, 1);
    data_wr(8'h11);
    data_wr(8'h22);
    data_rd();

    // Palette write through code 3.
    ctrl_wr(8'h05, 1);
    ctrl_wr(8'hC0, 1);
    data_wr(8'h3F);

    // Register 1 write enables frame irq; vsync raises irq until the status read.
    ctrl_wr(8'h20, 1);
    ctrl_wr(8'h81, 1);
    check_irq("irq before vsync");
    pulse(4'b1000);
    check_irq("irq after vsync");
    ctrl_rd(4'b0000);
    check_irq("irq after status read");

    // Address wrap 3FFF -> 0000.
    ctrl_wr(8'hFF, 1);
    ctrl_wr(8'h7F, 1);
    data_wr(8'h5A);
    data_wr(8'hA5);

    // Data write during the prefetch wait cycle wins with a single increment.
    ctrl_wr(8'h10, 1);
    ctrl_wr(8'h02, 2);
    idle(1);
    data_wr(8'hC3);
    data_rd();

    // Control write during the wait cycle: no load, no increment (carry would show in addr[13:8]).
    vram[14'h01FF] = ~m_rdbuf;
    ref_mem[14'h01FF] = ~m_rdbuf;
    ctrl_wr(8'hFF, 1);
    ctrl_wr(8'h01, 2);
    idle(1);
    ctrl_wr(8'h77, 0);
    data_rd();

    // Collision pulse coincident with the status read keeps its flag.
    ctrl_rd(4'b0001);
    ctrl_rd(4'b0000);

    // Reset in the middle of a prefetch leaves the buffer cleared.
    data_wr(8'h99);
    ctrl_wr(8'h00, 0);
    ctrl_wr(8'h05, 0);
    reset_n = 1'b0;
    m_reset();
    idle(2);
    reset_n = 1'b1;
    idle(1);
    ctrl_rd(4'b0000);
    data_rd();

    // Randomized traffic against the model.
    for (int it = 0; it < 400; it++) begin
      case ($urandom_range(0, 6))
        0, 1: ctrl_wr(8'($urandom), 1);
        2:    data_wr(8'($urandom));
        3:    data_rd();
        4:    ctrl_rd(($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'd0);
        5:    pulse(($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'd0);
        default: check_irq("irq random");
      endcase
    end

    idle(4);
    chk("scoreboard drained", evq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
